// File: rtl/cordic_pkg.sv
// Shared types and constants for the iterative CORDIC vectoring sequencer.
// ATAN_TBL is present only when CORDIC_ANGLE_ACC_EN is defined.
package cordic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned LAT_ROT_DEF = 3;

`ifdef CORDIC_ANGLE_ACC_EN
    // round(atan(2^-i) * 2^15 / pi), binary angle with pi = 2^15
    localparam int unsigned ATAN_N = 16;
    localparam logic [15:0] ATAN_TBL [ATAN_N] = '{
        16'd8192, 16'd4836, 16'd2555, 16'd1297, 16'd651, 16'd326, 16'd163, 16'd81,
        16'd41,   16'd20,   16'd10,   16'd5,    16'd3,   16'd1,   16'd1,   16'd0
    };
`endif

endpackage

// File: rtl/cordic_atan_rom.sv
// Micro-rotation angle lookup: iteration index -> atan(2^-i) scaled to ASIZE bits.
// Only built when CORDIC_ANGLE_ACC_EN is defined.
`ifdef CORDIC_ANGLE_ACC_EN
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int unsigned ASIZE = 16
) (
    input  logic [7:0]       idx,
    output logic [ASIZE-1:0] angle
);

    logic [15:0] tbl;

    always_comb begin
        tbl = '0;
        case (idx)
            8'd0:    tbl = ATAN_TBL[0];
            8'd1:    tbl = ATAN_TBL[1];
            8'd2:    tbl = ATAN_TBL[2];
            8'd3:    tbl = ATAN_TBL[3];
            8'd4:    tbl = ATAN_TBL[4];
            8'd5:    tbl = ATAN_TBL[5];
            8'd6:    tbl = ATAN_TBL[6];
            8'd7:    tbl = ATAN_TBL[7];
            8'd8:    tbl = ATAN_TBL[8];
            8'd9:    tbl = ATAN_TBL[9];
            8'd10:   tbl = ATAN_TBL[10];
            8'd11:   tbl = ATAN_TBL[11];
            8'd12:   tbl = ATAN_TBL[12];
            8'd13:   tbl = ATAN_TBL[13];
            8'd14:   tbl = ATAN_TBL[14];
            8'd15:   tbl = ATAN_TBL[15];
            default: tbl = '0;
        endcase
    end

    // Table is stored in 16-bit format; rescale to the configured angle width
    if (ASIZE >= 16) begin : g_wide
        assign angle = ASIZE'(tbl) << (ASIZE - 16);
    end else begin : g_narrow
        assign angle = ASIZE'((32'(tbl) + (32'd1 << (15 - ASIZE))) >> (16 - ASIZE));
    end

endmodule
`endif

// File: rtl/cordic_vec_seq.sv
// Iterative CORDIC vectoring sequencer driving external master/slaver rotation stages.
// Optional angle accumulator and out_angle port enabled by CORDIC_ANGLE_ACC_EN.
module cordic_vec_seq
    import cordic_pkg::*;
#(
`ifdef CORDIC_ANGLE_ACC_EN
    parameter int unsigned ASIZE   = 16,
`endif
    parameter int unsigned DSIZE   = 16,
    parameter int unsigned ITER    = 12,
    parameter int unsigned LAT_ROT = LAT_ROT_DEF
) (
    input  logic                    clock,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [DSIZE-1:0] in_x,
    input  logic signed [DSIZE-1:0] in_y,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [DSIZE-1:0] out_x,
    output logic signed [DSIZE-1:0] out_y,
`ifdef CORDIC_ANGLE_ACC_EN
    output logic        [ASIZE-1:0] out_angle,
`endif
    output logic signed [DSIZE-1:0] mst_din,
    output logic signed [DSIZE-1:0] mst_delta,
    output logic signed [DSIZE-1:0] slv_din,
    output logic signed [DSIZE-1:0] slv_delta,
    output logic                    mst_dir,
    output logic                    slv_dir,
    input  logic                    mst_exec,
    input  logic signed [DSIZE-1:0] mst_dout,
    input  logic signed [DSIZE-1:0] slv_dout
);

    localparam int unsigned IW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int unsigned WW = (LAT_ROT > 0) ? $clog2(LAT_ROT + 1) : 1;

    state_t                 state, state_nxt;
    logic signed [DSIZE-1:0] x, y;
    logic [IW-1:0]          i;
    logic [WW-1:0]          wait_cnt;
    logic                   accept_c, sample_c, last_c;

    assign accept_c = (state == IDLE) && in_valid;
    assign sample_c = (state == ROT) && (wait_cnt == WW'(LAT_ROT));
    assign last_c   = sample_c && (i == IW'(ITER - 1));

    // Stage operands follow the working registers; held for LAT_ROT+1 cycles per step
    assign mst_din   = y;
    assign mst_delta = x >>> i;
    assign slv_din   = x;
    assign slv_delta = y >>> i;
    assign mst_dir   = ~(x[DSIZE-1] ^ y[DSIZE-1]);
    assign slv_dir   = ~mst_dir;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = ROT;
            ROT:     if (last_c)    state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Working vector, iteration index and settle counter; results captured on last step
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            x        <= '0;
            y        <= '0;
            i        <= '0;
            wait_cnt <= '0;
            out_x    <= '0;
            out_y    <= '0;
        end else if (accept_c) begin
            x        <= in_x[DSIZE-1] ? -in_x : in_x;
            y        <= in_x[DSIZE-1] ? -in_y : in_y;
            i        <= '0;
            wait_cnt <= '0;
        end else if (sample_c) begin
            x        <= slv_dout;
            y        <= mst_dout;
            i        <= i + IW'(1);
            wait_cnt <= '0;
            if (last_c) begin
                out_x <= slv_dout;
                out_y <= mst_dout;
            end
        end else if (state == ROT) begin
            wait_cnt <= wait_cnt + WW'(1);
        end
    end

`ifdef CORDIC_ANGLE_ACC_EN
    localparam logic [ASIZE-1:0] ANG_PI = {1'b1, {(ASIZE-1){1'b0}}};

    logic [ASIZE-1:0] angle, angle_nxt_c, atan_c;

    cordic_atan_rom #(.ASIZE(ASIZE)) u_atan_rom (
        .idx   (8'(i)),
        .angle (atan_c)
    );

    always_comb begin
        angle_nxt_c = angle;
        if (mst_exec) angle_nxt_c = mst_dir ? angle + atan_c : angle - atan_c;
    end

    // Angle starts at -pi when the input was pre-rotated into the right half-plane
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            angle     <= '0;
            out_angle <= '0;
        end else if (accept_c) begin
            angle <= in_x[DSIZE-1] ? ANG_PI : '0;
        end else if (sample_c) begin
            angle <= angle_nxt_c;
            if (last_c) out_angle <= angle_nxt_c;
        end
    end
`else
    logic unused_exec;
    assign unused_exec = mst_exec;
`endif

endmodule
